// File: rtl/mark_track_ctrl.sv
// mark_track_ctrl: frame-synchronous acquire/track/coast controller for the VGA marker overlay (optional MARK_SMOOTH_EN smoothing)
module mark_track_ctrl #(
   parameter int IMG_W        = 800,
   parameter int IMG_H        = 600,
   parameter int ACQ_FRAMES   = 2,
   parameter int COAST_FRAMES = 8,
   parameter int DEF_SIZE     = 64
`ifdef MARK_SMOOTH_EN
   ,parameter int SMOOTH_SHIFT = 2
`endif
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        pre_vs,
   input  logic        det_valid,
   output logic        det_ready,
   input  logic [10:0] det_x,
   input  logic [10:0] det_y,
   input  logic [10:0] det_size,
   output logic [10:0] px,
   output logic [10:0] py,
   output logic [10:0] a,
   output logic        mark_en,
   output logic [1:0]  trk_state,
   output logic        lost_pulse
);
   typedef enum logic [1:0] {IDLE = 2'd0, ACQUIRE = 2'd1, TRACK = 2'd2, COAST = 2'd3} state_t;
   localparam logic [10:0] X_MAX = 11'(IMG_W - 1);
   localparam logic [10:0] Y_MAX = 11'(IMG_H - 1);
   localparam logic [10:0] S_MIN = 11'd8;
   localparam logic [10:0] X_MID = 11'(IMG_W / 2);
   localparam logic [10:0] Y_MID = 11'(IMG_H / 2);
   localparam logic [10:0] S_DEF = 11'(DEF_SIZE);
   localparam logic [7:0]  ACQ_N = 8'(ACQ_FRAMES);
   localparam logic [7:0]  COAST_N = 8'(COAST_FRAMES);
   state_t      state, state_nxt;
   logic        vs_d, fb, pend_vld, lost_nxt;
   logic [10:0] pend_x, pend_y, pend_s, ux, uy, ua, px_nxt, py_nxt, a_nxt;
   logic [7:0]  hit_cnt, hit_nxt, miss_cnt, miss_nxt;
   assign fb        = pre_vs & ~vs_d;
   assign det_ready = ~fb;
   assign mark_en   = state[1];
   assign trk_state = state;
`ifdef MARK_SMOOTH_EN
   // v + ((d - v) >>> SMOOTH_SHIFT), bounded to [lo, hi]
   function automatic logic [10:0] smooth(input logic [10:0] v, input logic [10:0] d,
                                          input logic [10:0] lo, input logic [10:0] hi);
      logic signed [11:0] diff, step;
      logic signed [12:0] sum;
      diff = $signed({1'b0, d}) - $signed({1'b0, v});
      step = diff >>> SMOOTH_SHIFT;
      sum  = $signed({2'b00, v}) + $signed({step[11], step});
      return (sum < $signed({2'b00, lo})) ? lo : (sum > $signed({2'b00, hi})) ? hi : sum[10:0];
   endfunction
   assign ux = smooth(px, pend_x, 11'd0, X_MAX);
   assign uy = smooth(py, pend_y, 11'd0, Y_MAX);
   assign ua = smooth(a, pend_s, S_MIN, 11'h7FF);
`else
   assign ux = pend_x;
   assign uy = pend_y;
   assign ua = pend_s;
`endif
   // frame-edge history and last-wins clamped pending detection
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vs_d     <= 1'b0;
         pend_vld <= 1'b0;
         pend_x   <= '0;
         pend_y   <= '0;
         pend_s   <= '0;
      end else begin
         vs_d <= pre_vs;
         if (fb) pend_vld <= 1'b0;
         else if (det_valid) begin
            pend_vld <= 1'b1;
            pend_x   <= (det_x > X_MAX) ? X_MAX : det_x;
            pend_y   <= (det_y > Y_MAX) ? Y_MAX : det_y;
            pend_s   <= (det_size < S_MIN) ? S_MIN : det_size;
         end
      end
   end
   // tracker state and committed marker registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         px         <= X_MID;
         py         <= Y_MID;
         a          <= S_DEF;
         hit_cnt    <= '0;
         miss_cnt   <= '0;
         lost_pulse <= 1'b0;
      end else begin
         state      <= state_nxt;
         px         <= px_nxt;
         py         <= py_nxt;
         a          <= a_nxt;
         hit_cnt    <= hit_nxt;
         miss_cnt   <= miss_nxt;
         lost_pulse <= lost_nxt;
      end
   end
   // next state and commit values; everything holds except on a frame boundary
   always_comb begin
      state_nxt = state;
      px_nxt    = px;
      py_nxt    = py;
      a_nxt     = a;
      hit_nxt   = hit_cnt;
      miss_nxt  = miss_cnt;
      lost_nxt  = 1'b0;
      if (fb) begin
         case (state)
            IDLE: if (pend_vld) begin
               {px_nxt, py_nxt, a_nxt} = {pend_x, pend_y, pend_s};
               hit_nxt   = 8'd1;
               state_nxt = (ACQ_FRAMES == 1) ? TRACK : ACQUIRE;
            end
            ACQUIRE: if (pend_vld) begin
               {px_nxt, py_nxt, a_nxt} = {ux, uy, ua};
               hit_nxt   = hit_cnt + 8'd1;
               state_nxt = (hit_nxt >= ACQ_N) ? TRACK : ACQUIRE;
            end else begin
               hit_nxt   = '0;
               state_nxt = IDLE;
            end
            default: if (pend_vld) begin
               {px_nxt, py_nxt, a_nxt} = {ux, uy, ua};
               miss_nxt  = '0;
               state_nxt = TRACK;
            end else begin
               miss_nxt  = (state == TRACK) ? 8'd1 : miss_cnt + 8'd1;
               state_nxt = COAST;
               if (miss_nxt >= COAST_N) begin
                  miss_nxt  = '0;
                  hit_nxt   = '0;
                  lost_nxt  = 1'b1;
                  state_nxt = IDLE;
               end
            end
         endcase
      end
   end
endmodule

// File: tb/tb_mark_track_ctrl.sv
// tb_mark_track_ctrl: directed plus randomized frames against a streak-based reference model of the marker controller
module tb_mark_track_ctrl;
   localparam int IMG_W = 800, IMG_H = 600, ACQ = 2, COAST = 8, DEF = 64;
`ifdef MARK_SMOOTH_EN
   localparam int SH = 2;
`else
   localparam int SH = 0;
`endif
   typedef struct {int x; int y; int s;} det_t;
   logic        clk = 1'b0, rst_n = 1'b0, pre_vs = 1'b0, det_valid = 1'b0;
   logic [10:0] det_x = '0, det_y = '0, det_size = '0;
   logic        det_ready, mark_en, lost_pulse;
   logic [10:0] px, py, a;
   logic [1:0]  trk_state;
   int errors = 0, checks = 0;
   int m_px, m_py, m_a, p_x, p_y, p_s, hit_streak, miss_streak;
   bit tracking, m_lost, m_pend;
   det_t dq[$];

   mark_track_ctrl #(.IMG_W(IMG_W), .IMG_H(IMG_H), .ACQ_FRAMES(ACQ), .COAST_FRAMES(COAST), .DEF_SIZE(DEF)) dut (
      .clk(clk), .rst_n(rst_n), .pre_vs(pre_vs), .det_valid(det_valid), .det_ready(det_ready),
      .det_x(det_x), .det_y(det_y), .det_size(det_size), .px(px), .py(py), .a(a),
      .mark_en(mark_en), .trk_state(trk_state), .lost_pulse(lost_pulse));

   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   function automatic int clampi(input int v, input int lo, input int hi);
      return (v < lo) ? lo : (v > hi) ? hi : v;
   endfunction

   function automatic int upd(input int v, input int d);
      int diff, div, step;
      diff = d - v;
      div  = 1 << SH;
      step = (diff >= 0) ? diff / div : -((-diff + div - 1) / div);
      return v + step;
   endfunction

   function automatic int m_state();
      return tracking ? ((miss_streak > 0) ? 3 : 2) : ((hit_streak > 0) ? 1 : 0);
   endfunction

   task automatic model_reset();
      m_px = IMG_W / 2; m_py = IMG_H / 2; m_a = DEF;
      hit_streak = 0; miss_streak = 0; tracking = 0; m_lost = 0; m_pend = 0;
   endtask

   task automatic model_accept(input int x, input int y, input int s);
      m_pend = 1;
      p_x = clampi(x, 0, IMG_W - 1);
      p_y = clampi(y, 0, IMG_H - 1);
      p_s = clampi(s, 8, 2047);
   endtask

   task automatic model_commit();
      bit direct;
      m_lost = 0;
      if (m_pend) begin
         direct = !tracking && hit_streak == 0;
         m_px = direct ? p_x : upd(m_px, p_x);
         m_py = direct ? p_y : upd(m_py, p_y);
         m_a  = direct ? p_s : upd(m_a, p_s);
         hit_streak++;
         miss_streak = 0;
         if (hit_streak >= ACQ) tracking = 1;
      end else begin
         hit_streak = 0;
         if (tracking) begin
            miss_streak++;
            if (miss_streak >= COAST) begin
               tracking = 0; miss_streak = 0; m_lost = 1;
            end
         end
      end
      m_pend = 0;
   endtask

   task automatic check_outs(input string tag);
      chk({tag, ".px"}, 32'(px), 32'(m_px));
      chk({tag, ".py"}, 32'(py), 32'(m_py));
      chk({tag, ".a"}, 32'(a), 32'(m_a));
      chk({tag, ".state"}, 32'(trk_state), 32'(m_state()));
      chk({tag, ".mark_en"}, 32'(mark_en), 32'(tracking));
      chk({tag, ".lost"}, 32'(lost_pulse), 32'(m_lost));
   endtask

   task automatic check_reset_vals(input string tag);
      chk({tag, ".px"}, 32'(px), 400);
      chk({tag, ".py"}, 32'(py), 300);
      chk({tag, ".a"}, 32'(a), 64);
      chk({tag, ".mark_en"}, 32'(mark_en), 0);
      chk({tag, ".state"}, 32'(trk_state), 0);
      chk({tag, ".lost"}, 32'(lost_pulse), 0);
      chk({tag, ".ready"}, 32'(det_ready), 1);
   endtask

   // one frame: boundary (optionally with a detection offered in the fb cycle), then queued detections
   task automatic frame(input bit fb_det, input int hold);
      det_t d;
      @(negedge clk);
      pre_vs = 1'b1;
      if (fb_det) begin
         det_valid = 1'b1;
         det_x = 11'($urandom_range(0, 1023));
         det_y = 11'($urandom_range(0, 1023));
         det_size = 11'($urandom_range(0, 127));
      end
      #1 chk("ready_in_fb", 32'(det_ready), 0);
      @(posedge clk);
      model_commit();
      #1 check_outs("fb");
      @(negedge clk);
      chk("ready_after_fb", 32'(det_ready), 1);
      @(posedge clk);
      if (fb_det) model_accept(int'(det_x), int'(det_y), int'(det_size));
      m_lost = 0;
      #1 check_outs("post_fb");
      @(negedge clk);
      det_valid = 1'b0;
      repeat (hold) @(negedge clk);
      pre_vs = 1'b0;
      while (dq.size() > 0) begin
         d = dq.pop_front();
         det_valid = 1'b1;
         det_x = 11'(d.x); det_y = 11'(d.y); det_size = 11'(d.s);
         @(posedge clk);
         model_accept(d.x, d.y, d.s);
         @(negedge clk);
         det_valid = 1'b0;
         det_x = 11'($urandom);
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      repeat (3) @(negedge clk);
      check_outs("stable");
   endtask

   initial begin
      int mode_left, n;
      bit good, hit;
      model_reset();
      repeat (3) @(negedge clk);
      check_reset_vals("reset");
      rst_n = 1'b1;
      repeat (5) frame(0, 0);
      check_reset_vals("idle5");
      dq.push_back('{500, 200, 40});
      frame(0, 1);
      dq.push_back('{500, 200, 40});
      frame(0, 0);
      frame(0, 2);
      chk("acq.state", 32'(trk_state), 2);
      chk("acq.mark_en", 32'(mark_en), 1);
      chk("acq.px", 32'(px), 500);
      chk("acq.py", 32'(py), 200);
      chk("acq.a", 32'(a), 40);
      for (int i = 0; i < COAST; i++) frame(0, 0);
      chk("lost.state", 32'(trk_state), 0);
      chk("lost.px", 32'(px), 500);
      chk("lost.py", 32'(py), 200);
      dq.push_back('{100, 100, 20});
      dq.push_back('{900, 700, 4});
      frame(0, 0);
      frame(0, 0);
      chk("clamp.px", 32'(px), 799);
      chk("clamp.py", 32'(py), 599);
      chk("clamp.a", 32'(a), 8);
      frame(1, 0);
      frame(0, 0);
      frame(0, 0);
      mode_left = 0;
      good = 0;
      for (int i = 0; i < 150; i++) begin
         if (mode_left == 0) begin
            good = 1'($urandom_range(0, 1));
            mode_left = $urandom_range(1, 12);
         end
         mode_left--;
         hit = good ? ($urandom_range(0, 9) < 9) : ($urandom_range(0, 9) < 1);
         if (hit) begin
            n = $urandom_range(1, 3);
            for (int k = 0; k < n; k++)
               dq.push_back('{int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)), int'($urandom_range(0, 127))});
         end
         frame($urandom_range(0, 7) == 0, $urandom_range(0, 3));
      end
      dq.push_back('{300, 320, 30});
      frame(0, 0);
      dq.push_back('{310, 330, 32});
      frame(0, 0);
      frame(0, 0);
      frame(0, 0);
      chk("pre_rst.state", 32'(trk_state), 3);
      det_valid = 1'b1;
      det_x = 11'd50; det_y = 11'd60; det_size = 11'd70;
      @(posedge clk);
      model_accept(50, 60, 70);
      @(negedge clk);
      det_valid = 1'b0;
      repeat (2) @(posedge clk);
      #3 rst_n = 1'b0;
      #1 check_reset_vals("async_rst");
      model_reset();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      frame(0, 0);
      chk("post_rst.state", 32'(trk_state), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
